// File: rtl/pc_tx_word_serialiser.sv
// PC_TX word serialiser: sends a 32-bit word as four UART 8N1 bytes.
// Optional one-entry request queue enabled by defining PC_TX_WORD_QUEUE_EN.
`timescale 1ns/1ps

module pc_tx_word_serialiser #(
  parameter int CLKS_PER_BIT   = 434,
  parameter bit MSB_BYTE_FIRST = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_tx_word,
  input  logic        i_tx_next_cmd,
  output logic        o_tx_serial,
  output logic        o_tx_busy,
  output logic        o_tx_word_done,
  output logic        o_tx_dropped
);

  localparam int                 CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [31:0]       word_reg, word_reg_n;
  logic [7:0]        shift_reg, shift_reg_n;
  logic              serial_q, serial_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              dropped_q, dropped_n;
  logic              tick;
  logic              word_end;
  logic              launch;
  logic [31:0]       launch_word;

`ifdef PC_TX_WORD_QUEUE_EN
  logic [31:0]       hold_word, hold_word_n;
  logic              hold_valid, hold_valid_n;
  logic              chain_direct;
  logic              hold_free;
`endif

  // Byte slot k of the transmit order maps to word byte (3-k) or k.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [1:0] k;
    k = MSB_BYTE_FIRST ? (2'd3 - idx) : idx;
    return word[{k, 3'b000} +: 8];
  endfunction

  assign tick     = (bit_cnt == '0);
  assign word_end = (state == S_STOP) && tick && (byte_idx == 2'd3);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    bit_idx_n   = bit_idx;
    byte_idx_n  = byte_idx;
    word_reg_n  = word_reg;
    shift_reg_n = shift_reg;
    serial_n    = serial_q;
    busy_n      = busy_q;
    done_n      = 1'b0;
    dropped_n   = 1'b0;
    launch      = 1'b0;
    launch_word = word_reg;
`ifdef PC_TX_WORD_QUEUE_EN
    hold_word_n  = hold_word;
    hold_valid_n = hold_valid;
    chain_direct = 1'b0;
    hold_free    = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        serial_n = 1'b1;
        if (i_tx_next_cmd) begin
          launch      = 1'b1;
          launch_word = i_tx_word;
        end
      end

      S_START: begin
        if (tick) begin
          state_n   = S_DATA;
          bit_cnt_n = CNT_RELOAD;
          bit_idx_n = 3'd0;
          serial_n  = shift_reg[0];
        end else begin
          bit_cnt_n = bit_cnt - 1'b1;
        end
      end

      S_DATA: begin
        if (tick) begin
          bit_cnt_n = CNT_RELOAD;
          if (bit_idx == 3'd7) begin
            state_n  = S_STOP;
            serial_n = 1'b1;
          end else begin
            bit_idx_n   = bit_idx + 3'd1;
            shift_reg_n = {1'b0, shift_reg[7:1]};
            serial_n    = shift_reg[1];
          end
        end else begin
          bit_cnt_n = bit_cnt - 1'b1;
        end
      end

      S_STOP: begin
        if (tick) begin
          if (byte_idx != 2'd3) begin
            byte_idx_n  = byte_idx + 2'd1;
            state_n     = S_START;
            bit_cnt_n   = CNT_RELOAD;
            shift_reg_n = pick_byte(word_reg, byte_idx + 2'd1);
            serial_n    = 1'b0;
          end else begin
            done_n   = 1'b1;
            state_n  = S_IDLE;
            busy_n   = 1'b0;
            serial_n = 1'b1;
`ifdef PC_TX_WORD_QUEUE_EN
            // A queued word, or a request landing on this very edge, starts with no gap.
            if (hold_valid) begin
              launch       = 1'b1;
              launch_word  = hold_word;
              hold_valid_n = 1'b0;
            end else if (i_tx_next_cmd) begin
              launch       = 1'b1;
              launch_word  = i_tx_word;
              chain_direct = 1'b1;
            end
`endif
          end
        end else begin
          bit_cnt_n = bit_cnt - 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase

    if (launch) begin
      state_n     = S_START;
      bit_cnt_n   = CNT_RELOAD;
      bit_idx_n   = 3'd0;
      byte_idx_n  = 2'd0;
      word_reg_n  = launch_word;
      shift_reg_n = pick_byte(launch_word, 2'd0);
      serial_n    = 1'b0;
      busy_n      = 1'b1;
    end

`ifdef PC_TX_WORD_QUEUE_EN
    // The hold slot frees on the edge it is consumed, so a request there is kept.
    hold_free = !hold_valid || word_end;
    if (i_tx_next_cmd && busy_q && !chain_direct) begin
      if (hold_free) begin
        hold_word_n  = i_tx_word;
        hold_valid_n = 1'b1;
      end else begin
        dropped_n = 1'b1;
      end
    end
`else
    if (i_tx_next_cmd && busy_q) begin
      dropped_n = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      byte_idx  <= 2'd0;
      word_reg  <= 32'd0;
      shift_reg <= 8'd0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
`ifdef PC_TX_WORD_QUEUE_EN
      hold_word  <= 32'd0;
      hold_valid <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      bit_idx   <= bit_idx_n;
      byte_idx  <= byte_idx_n;
      word_reg  <= word_reg_n;
      shift_reg <= shift_reg_n;
      serial_q  <= serial_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      dropped_q <= dropped_n;
`ifdef PC_TX_WORD_QUEUE_EN
      hold_word  <= hold_word_n;
      hold_valid <= hold_valid_n;
`endif
    end
  end

  assign o_tx_serial    = serial_q;
  assign o_tx_busy      = busy_q;
  assign o_tx_word_done = done_q;
  assign o_tx_dropped   = dropped_q;

endmodule
